xadc_stream_arbiter: RTL
========================

// Module: xadc_stream_arbiter
// PURPOSE
//  Shares the single 8-bit FT232H sys_axis stream between the two 16-bit XADC
//  AXIS channels (voltage, current monitor) from xadc_drp_axis_adapter.
//  Round-robin grants one sample at a time and serialises it into a 2-byte
//  self-synchronising frame. Disabled channels are drained so the adapter never stalls.
//  Sits between xadc_drp_axis_adapter and ft232h, in the sys_clk domain.
// PARAMETERS
//  IN_WIDTH    16   input tdata width
//  SAMPLE_LSB  4    LSB of the 12-bit XADC sample within tdata (sample = tdata[SAMPLE_LSB+:12])
//  CNT_WIDTH   16   width of frame_count / drop_count
// PORTS
//  clk           in   1          sys_clk
//  rst_n         in   1          async active-low reset
//  ch_en         in   2          [0]=voltage, [1]=current enable; sampled only at arbitration
//  v_tdata       in   IN_WIDTH   voltage channel data
//  v_tvalid      in   1          voltage channel valid
//  v_tready      out  1          voltage channel ready
//  c_tdata       in   IN_WIDTH   current channel data
//  c_tvalid      in   1          current channel valid
//  c_tready      out  1          current channel ready
//  m_tdata       out  8          frame byte to ft232h sys_axis
//  m_tvalid      out  1          output valid
//  m_tlast       out  1          high on second byte of frame
//  m_tready      in   1          ft232h ready
//  frame_count   out  CNT_WIDTH  frames fully sent, wraps
//  drop_count    out  CNT_WIDTH  samples discarded from disabled channels, saturates at all-ones
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//  Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, counters=0, state=IDLE, last_grant=1 (voltage wins first).
//  Frame, s = 12-bit sample, ch = 0 voltage / 1 current:
//    byte0 = {1'b1, ch, s[11:6]}
//    byte1 = {1'b0, 1'b0, s[5:0]}, m_tlast=1
//    The MSB is the host resync marker.
//  FSM: IDLE -> SEND_HI -> SEND_LO -> (IDLE | SEND_HI).
//  Arbitration point = IDLE, or SEND_LO with m_tvalid&&m_tready.
//    Candidates = enabled channels with tvalid.
//    Both candidates: grant the channel != last_grant. One candidate: grant it. None: go to IDLE.
//    Grant: granted tready=1 that cycle; sample, ch latched into hold regs; last_grant updated.
//    Next state SEND_HI with byte0 registered on m_tdata.
//    Latency: input handshake at cycle N gives byte0 valid at N+1.
//    Back-to-back: sustains 1 byte/cycle, i.e. 1 sample per 2 cycles.
//  SEND_HI: hold m_tdata/m_tvalid stable until m_tready; then load byte1 with m_tlast=1 -> SEND_LO.
//  SEND_LO: on handshake, frame_count++ (wraps), then arbitrate as above.
//  m_tdata/m_tvalid/m_tlast never change while m_tvalid=1 and m_tready=0 (AXIS rule).
//  Disabled channel (ch_en bit 0): tready=1 constantly in every state; each tvalid beat discarded.
//    drop_count++ per discarded beat; both channels dropping in one cycle adds 2; saturating.
//  Enabled channel not granted: tready=0 (back-pressure held by adapter).
//  ch_en deasserted mid-frame: the current frame completes; the change takes effect at the next arbitration.
//  Both disabled: m_tvalid stays 0 after the current frame; both inputs drain.
//  tready may depend combinationally on the other channel's tvalid (allowed by AXIS).
//    No path exists from m_tready to s_tready other than through the arbitration condition.
//  Reset mid-frame: the partial frame is abandoned, with outputs immediately at reset values.
//    The host resyncs on the next byte with MSB=1.
// STRUCTURE
//  Shared package xadc_stream_pkg:
//    typedef enum logic[1:0] {IDLE, SEND_HI, SEND_LO} xadc_arb_state_t
//    CH_VOLTAGE=1'b0, CH_CURRENT=1'b1, FRAME_SYNC_BIT=7
//    function build_frame_hi/lo(ch, sample)
//  One sub-module: rr_arbiter_2 (2-requester round-robin; inputs req[1:0], advance, outputs grant one-hot).
//  Top instantiation: the voltage/current axis_interface Sources connect to v_*/c_*; m_* drives sys_axis.
// TESTING
//  1 Reset, ch_en=2'b01, single v sample tdata=16'hABC0, m_tready=1
//    -> bytes 8'hAA, 8'h3C (tlast); frame_count=1.
//  2 Both enabled and continuously valid, m_tready=1
//    -> frames alternate V,C,V,C starting with V; one byte every cycle after the first; no bubbles.
//  3 m_tready toggled randomly
//    -> m_tdata/m_tvalid stable while stalled; byte order intact; v_tready=0 while frame pending.
//  4 ch_en=2'b01, c_tvalid=1 for 10 cycles
//    -> c_tready=1 throughout; drop_count=10; no C frames emitted.
//  5 ch_en cleared between byte0 and byte1
//    -> byte1 still sent; no new frames; m_tvalid=0 after it.
//  6 rst_n asserted in SEND_HI
//    -> m_tvalid=0 asynchronously; after release the first byte out has MSB=1 and
//       the first grant goes to voltage.

Source files
------------

// File: rtl/xadc_stream_pkg.sv
// Shared types and frame helpers for the XADC stream arbiter.
// Converts 12-bit XADC samples into 2-byte frames that the host can resync on.
package xadc_stream_pkg;

    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} xadc_arb_state_t;

    localparam logic        CH_VOLTAGE     = 1'b0;
    localparam logic        CH_CURRENT     = 1'b1;
    localparam int unsigned FRAME_SYNC_BIT = 7;
    localparam int unsigned SAMPLE_WIDTH   = 12;

    typedef struct packed {
        logic                    ch;
        logic [SAMPLE_WIDTH-1:0] sample;
    } xadc_hold_t;

    // First frame byte: sync marker, channel id, sample[11:6]
    function automatic logic [7:0] build_frame_hi(input logic ch, input logic [SAMPLE_WIDTH-1:0] sample);
        logic [7:0] b;
        b                 = 8'(sample >> 6);
        b[6]              = ch;
        b[FRAME_SYNC_BIT] = 1'b1;
        return b;
    endfunction

    // Second frame byte: marker clear, sample[5:0]
    function automatic logic [7:0] build_frame_lo(input logic [SAMPLE_WIDTH-1:0] sample);
        return 8'(sample & 12'h03F);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; combinational one-hot grant with
// the last winner remembered across arbitration points.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to 1 so voltage wins the first contended arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance && (|req)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/xadc_stream_arbiter.sv
// Round-robin merge of the voltage/current XADC streams onto the 8-bit
// FT232H stream, one 2-byte frame per sample; disabled channels are drained.
module xadc_stream_arbiter
    import xadc_stream_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned SAMPLE_LSB = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           ch_en,
    input  logic [IN_WIDTH-1:0]  v_tdata,
    input  logic                 v_tvalid,
    output logic                 v_tready,
    input  logic [IN_WIDTH-1:0]  c_tdata,
    input  logic                 c_tvalid,
    output logic                 c_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned SUM_W = CNT_WIDTH + 1;

    xadc_arb_state_t         state;
    xadc_hold_t              hold;
    xadc_hold_t              next_hold;
    logic                    arb_point;
    logic [1:0]              req;
    logic [1:0]              grant;
    logic [1:0]              take;
    logic [1:0]              drop;
    logic [SUM_W-1:0]        drop_sum;
    logic [CNT_WIDTH-1:0]    drop_next;
    logic [SAMPLE_WIDTH-1:0] v_sample;
    logic [SAMPLE_WIDTH-1:0] c_sample;
    logic                    unused_tdata;

    assign v_sample     = v_tdata[SAMPLE_LSB +: SAMPLE_WIDTH];
    assign c_sample     = c_tdata[SAMPLE_LSB +: SAMPLE_WIDTH];
    assign unused_tdata = ^{v_tdata, c_tdata};

    assign arb_point = (state == IDLE) || ((state == SEND_LO) && m_tvalid && m_tready);
    assign req       = ch_en & {c_tvalid, v_tvalid};

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (arb_point),
        .grant   (grant)
    );

    // Disabled channels are always ready; enabled ones only when granted
    assign take     = arb_point ? grant : 2'b00;
    assign v_tready = ~ch_en[0] | take[0];
    assign c_tready = ~ch_en[1] | take[1];
    assign drop     = {~ch_en[1] & c_tvalid, ~ch_en[0] & v_tvalid};

    always_comb begin
        next_hold.ch     = take[1] ? CH_CURRENT : CH_VOLTAGE;
        next_hold.sample = take[1] ? c_sample : v_sample;
    end

    // Saturating drop accumulator; up to two discards per cycle
    assign drop_sum  = SUM_W'(drop_count) + SUM_W'(drop[0]) + SUM_W'(drop[1]);
    assign drop_next = drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold        <= '0;
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            drop_count <= drop_next;
            case (state)
                SEND_HI: begin
                    if (m_tready) begin
                        m_tdata <= build_frame_lo(hold.sample);
                        m_tlast <= 1'b1;
                        state   <= SEND_LO;
                    end
                end
                default: begin
                    if (arb_point) begin
                        if (state == SEND_LO) begin
                            frame_count <= frame_count + CNT_WIDTH'(1);
                        end
                        if (|take) begin
                            hold     <= next_hold;
                            m_tdata  <= build_frame_hi(next_hold.ch, next_hold.sample);
                            m_tvalid <= 1'b1;
                            m_tlast  <= 1'b0;
                            state    <= SEND_HI;
                        end else begin
                            m_tdata  <= '0;
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
